// File: rtl/nub_sched_pkg.sv
// nub_sched_pkg
// Shared definitions for the time-step scheduler that drives out_nu_blk.
//   nub_state_t : scheduler FSM state encoding
//   cnt_w()     : width of a counter that must hold values 0..max_val
package nub_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_INCR  = 3'd4,
        ST_GAP   = 3'd5,
        ST_DONE  = 3'd6
    } nub_state_t;

    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/nub_spike_tally.sv
// nub_spike_tally
// Per-neuron saturating spike counters with a registered argmax.
// Only instantiated by nub_step_sched when NUB_TALLY_EN is defined.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : zero all counters and the winner (run start)
//   inc_en    : one-cycle strobe, add spikes[] into the counters
//   spikes    : per-neuron spike flags for the step being counted
//   spk_cnt   : packed counters, neuron i at [i*CW +: CW]
//   winner    : lowest index holding the maximum count (0 when all zero)
module nub_spike_tally #(
    parameter int N  = 3,
    parameter int CW = 8,
    parameter int WW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc_en,
    input  logic [N-1:0]    spikes,
    output logic [N*CW-1:0] spk_cnt,
    output logic [WW-1:0]   winner
);

    logic [CW-1:0] cnt_p0 [N];
    logic [CW-1:0] best_cnt;
    logic [WW-1:0] best_idx;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    // stage p0: counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) cnt_p0[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < N; i++) cnt_p0[i] <= '0;
        end else if (inc_en) begin
            for (int i = 0; i < N; i++)
                if (spikes[i]) cnt_p0[i] <= sat_inc(cnt_p0[i]);
        end
    end

    // Strict '>' keeps the lowest index on ties.
    always_comb begin
        best_cnt = cnt_p0[0];
        best_idx = '0;
        for (int i = 1; i < N; i++) begin
            if (cnt_p0[i] > best_cnt) begin
                best_cnt = cnt_p0[i];
                best_idx = WW'(i);
            end
        end
    end

    // stage p1: winner follows the counters one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      winner <= '0;
        else if (clr) winner <= '0;
        else          winner <= best_idx;
    end

    always_comb begin
        spk_cnt = '0;
        for (int i = 0; i < N; i++) spk_cnt[i*CW +: CW] = cnt_p0[i];
    end

endmodule

// File: rtl/nub_step_sched.sv
// nub_step_sched
// Time-step scheduler for out_nu_blk: fetches one M-bit spike vector per
// time unit, starts the neuron block, waits for its result, pulses TU_incre,
// idles GAP cycles and repeats for num_steps time units.
// Optional feature macro: NUB_TALLY_EN adds per-neuron spike counters
// (spk_cnt) and an argmax (winner); without it those ports do not exist.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   run_start, num_steps          : start request and step count
//   in_valid, in_spikes, in_ready : upstream spike-vector handshake
//   spike_ip_nub, start_op_nub    : to out_nu_blk
//   valid_op_nub, spike_op_nub    : from out_nu_blk
//   TU_incre, TU                  : time-unit advance pulse / current unit
//   step_valid, step_spikes       : per-step result
//   busy, done, err_timeout       : run status
//   spk_cnt, winner               : tally outputs (NUB_TALLY_EN)
module nub_step_sched
    import nub_sched_pkg::*;
#(
    parameter int M   = 10,
    parameter int N   = 3,
    parameter int TW  = 16,
    parameter int GAP = 4,
    parameter int TMO = 255
`ifdef NUB_TALLY_EN
    ,
    parameter int CW  = 8,
    parameter int WW  = (N > 1) ? $clog2(N) : 1
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run_start,
    input  logic [TW-1:0]   num_steps,
    input  logic            in_valid,
    input  logic [M-1:0]    in_spikes,
    output logic            in_ready,
    output logic [M-1:0]    spike_ip_nub,
    output logic            start_op_nub,
    input  logic            valid_op_nub,
    input  logic [N-1:0]    spike_op_nub,
    output logic            TU_incre,
    output logic [TW-1:0]   TU,
    output logic            step_valid,
    output logic [N-1:0]    step_spikes,
    output logic            busy,
    output logic            done,
    output logic            err_timeout
`ifdef NUB_TALLY_EN
    ,
    output logic [N*CW-1:0] spk_cnt,
    output logic [WW-1:0]   winner
`endif
);

    localparam int TMO_W = cnt_w(TMO);
    localparam int GAP_W = cnt_w(GAP);

    nub_state_t       state_p0, state_nx;
    logic [TW-1:0]    steps_p0;
    logic [TMO_W-1:0] tmo_cnt_p0;
    logic [GAP_W-1:0] gap_cnt_p0;
    logic [TW:0]      tu_nx;
    logic             last_step;
    logic             tmo_hit;

    // Extra bit so TU+1 never aliases when steps = 2^TW-1.
    assign tu_nx     = {1'b0, TU} + 1'b1;
    assign last_step = (tu_nx == {1'b0, steps_p0});
    assign tmo_hit   = (tmo_cnt_p0 == TMO_W'(TMO - 1));

    always_comb begin
        state_nx = state_p0;
        unique case (state_p0)
            ST_IDLE:  if (run_start) state_nx = (num_steps == '0) ? ST_DONE : ST_FETCH;
            ST_FETCH: if (in_valid) state_nx = ST_START;
            ST_START: state_nx = ST_WAIT;
            ST_WAIT: begin
                // a response in the expiry cycle still counts
                if (valid_op_nub) state_nx = ST_INCR;
                else if (tmo_hit) state_nx = ST_DONE;
            end
            ST_INCR:  state_nx = last_step ? ST_DONE : ST_GAP;
            ST_GAP:   if (gap_cnt_p0 == GAP_W'(GAP - 1)) state_nx = ST_FETCH;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // stage p0: state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p0     <= ST_IDLE;
            steps_p0     <= '0;
            tmo_cnt_p0   <= '0;
            gap_cnt_p0   <= '0;
            TU           <= '0;
            spike_ip_nub <= '0;
            step_spikes  <= '0;
            err_timeout  <= 1'b0;
        end else begin
            state_p0 <= state_nx;
            unique case (state_p0)
                ST_IDLE: begin
                    if (run_start) begin
                        err_timeout <= 1'b0;
                        if (num_steps != '0) begin
                            steps_p0 <= num_steps;
                            TU       <= '0;
                        end
                    end
                end
                ST_FETCH: if (in_valid) spike_ip_nub <= in_spikes;
                ST_START: tmo_cnt_p0 <= '0;
                ST_WAIT: begin
                    if (valid_op_nub) begin
                        step_spikes <= spike_op_nub;
                    end else begin
                        tmo_cnt_p0 <= tmo_cnt_p0 + 1'b1;
                        if (tmo_hit) err_timeout <= 1'b1;
                    end
                end
                ST_INCR: begin
                    gap_cnt_p0 <= '0;
                    if (!last_step) TU <= tu_nx[TW-1:0];
                end
                ST_GAP:  gap_cnt_p0 <= gap_cnt_p0 + 1'b1;
                default: ;
            endcase
        end
    end

    // Control outputs are pure state decodes.
    always_comb begin
        in_ready     = (state_p0 == ST_FETCH);
        start_op_nub = (state_p0 == ST_START);
        TU_incre     = (state_p0 == ST_INCR);
        step_valid   = (state_p0 == ST_INCR);
        done         = (state_p0 == ST_DONE);
        busy         = (state_p0 != ST_IDLE);
    end

`ifdef NUB_TALLY_EN
    logic tally_clr;
    assign tally_clr = (state_p0 == ST_IDLE) && run_start && (num_steps != '0);

    nub_spike_tally #(
        .N  (N),
        .CW (CW),
        .WW (WW)
    ) u_tally (
        .clk     (clk),
        .rst     (rst),
        .clr     (tally_clr),
        .inc_en  (state_p0 == ST_INCR),
        .spikes  (step_spikes),
        .spk_cnt (spk_cnt),
        .winner  (winner)
    );
`endif

endmodule

// File: doc/nub_step_sched.md
# nub_step_sched

Time-step scheduler for the output neuron block `out_nu_blk`. It pulls one M-bit input spike vector per time unit from an upstream valid/ready source and drives `spike_ip_nub`/`start_op_nub`. It waits for `valid_op_nub`, captures `spike_op_nub`, pulses `TU_incre`, inserts a settle gap, and repeats for a programmed number of time units. It sits between the input spike source and `out_nu_blk`, and reports per-step output spikes and run completion to the top level.

## Interface
- `M`, 10, input spike vector width (matches `out_nu_blk`)
- `N`, 3, number of output neurons
- `TW`, 16, time-unit counter width
- `GAP`, 4, idle cycles after `TU_incre` before the next fetch (≥1)
- `TMO`, 255, max cycles waited for `valid_op_nub` (≥1)
- `CW`, 8, per-neuron spike count width (`NUB_TALLY_EN` only)

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `run_start` in 1: one-cycle request to start a run; ignored while `busy`.
- `num_steps` in TW: time units per run; sampled on accepted `run_start`.
- `in_valid` in 1, `in_spikes` in M, `in_ready` out 1: upstream spike-vector handshake.
- `spike_ip_nub` out M, `start_op_nub` out 1: drive to `out_nu_blk`.
- `valid_op_nub` in 1, `spike_op_nub` in N: from `out_nu_blk`.
- `TU_incre` out 1: time-unit advance pulse to `out_nu_blk`.
- `TU` out TW: current time unit, 0-based.
- `step_valid` out 1, `step_spikes` out N: one-cycle per-step result.
- `busy` out 1, `done` out 1 (one-cycle pulse), `err_timeout` out 1 (sticky).
- `spk_cnt` out N*CW, `winner` out max(1,$clog2(N)): `NUB_TALLY_EN` only.

## Operation
- The FSM has states IDLE, FETCH, START, WAIT, INCR, GAP, DONE.
- **IDLE**
  - `run_start` with `num_steps`≠0: latch `num_steps`, TU←0, clear `err_timeout` and tallies, go to FETCH.
  - `run_start` with `num_steps`=0: clear `err_timeout`, go to DONE directly.
- **FETCH**
  - `in_ready`=1.
  - On `in_valid`: `spike_ip_nub`←`in_spikes`, go to START.
- **START**
  - `start_op_nub`=1 for exactly one cycle; clear the timeout counter; go to WAIT.
  - `spike_ip_nub` holds until the next FETCH acceptance.
- **WAIT**
  - On `valid_op_nub`: `step_spikes`←`spike_op_nub`, go to INCR.
  - Otherwise the timeout counter increments. When it reaches TMO: set `err_timeout`, go to DONE.
  - `valid_op_nub` in the same cycle as expiry: valid wins.
- **INCR**
  - `TU_incre`=1 and `step_valid`=1 for one cycle.
  - If TU+1 = latched steps: go to DONE. Otherwise TU←TU+1 and go to GAP.
- **GAP**: count GAP cycles, then go to FETCH.
- **DONE**: `done`=1 for one cycle, then go to IDLE.
- `busy`=1 in every state except IDLE.
- TU never wraps: maximum is 2^TW−2 on the final step.
- All outputs are decoded from registered state or registers only; no input-to-output combinational paths except none (`in_ready` is state-decoded).
- `valid_op_nub` outside WAIT is ignored.

## Timing
- Reset values:
  - state IDLE.
  - `TU`, `spike_ip_nub`, `step_spikes`, `spk_cnt`, `winner` = 0.
  - All 1-bit outputs = 0.
- Latency:
  - `run_start` at cycle c: `in_ready` high at c+1.
  - Vector accepted at cycle k: `start_op_nub` high at k+1.
  - `valid_op_nub` at cycle v: `TU_incre` and `step_valid` high at v+1.
  - Next `in_ready` at v+2+GAP.
- Step period with immediate `in_valid` and datapath latency L: 1 (FETCH) + 1 (START) + L + 1 (INCR) + GAP cycles.
- Final step: `done` at v+2, `busy` low at v+3.
- Reset asserted mid-run: immediate return to IDLE. Any in-flight `start_op_nub`/`TU_incre` is cut.

## Configuration
- `NUB_TALLY_EN`:
  - **Defined**:
    - On each INCR, `spk_cnt[i]` increments where `step_spikes[i]`=1, saturating at 2^CW−1.
    - `winner` is the lowest index of the maximum count, updated the cycle after each INCR.
    - All-zero counts give `winner`=0.
  - **Undefined**: `spk_cnt` and `winner` ports and all their logic are absent; scheduling is identical.

## Structure
- Package `nub_sched_pkg`: state enum `nub_state_t`, GAP/TMO counter-width helper function.
- Sub-module `nub_spike_tally`: counters plus argmax, instantiated only under `NUB_TALLY_EN`.

## Test plan
- Reset, then `run_start` with `num_steps`=3. A stub returns `valid_op_nub` 2 cycles after start.
  - Expect 3 `start_op_nub` pulses, 3 `TU_incre` pulses, TU = 0, 1, 2.
  - Expect `done` 2 cycles after the 3rd valid, and a step period of 9 cycles.
- `in_valid` withheld for 5 cycles in FETCH: `in_ready` stays 1, `start_op_nub` stays 0, and `spike_ip_nub` is unchanged until acceptance.
- Stub never responds, TMO=255: `err_timeout`=1 exactly 255 cycles after WAIT entry, then `done` pulse and IDLE. The next `run_start` clears `err_timeout`.
- `num_steps`=0: `done` at c+1, no `in_ready`, no `start_op_nub`.
- `rst` asserted during WAIT of step 2: all outputs are 0 within the same cycle. `run_start` while `busy` is ignored (TU is unaffected).
- `NUB_TALLY_EN`, 4 steps with `spike_op_nub` = 3'b010, 3'b110, 3'b010, 3'b100: `spk_cnt` = {2, 3, 0}, `winner`=1. With CW=2 and 5 spikes on neuron 0, the count saturates at 3.
